// File: rtl/kpg_prefix_adder_pipe.sv
// rtl/kpg_prefix_adder_pipe.sv - pipelined Kogge-Stone KPG adder/subtractor with valid/ready stages
// Stage 0 encodes KPG, stages 1..LEVELS do one doubling each, the last stage forms sum/cout/ovf.
module kpg_prefix_adder_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int LEVELS = $clog2(WIDTH);
   localparam int LAST   = LEVELS + 1;
   localparam logic [1:0] KPG_K = 2'b00;
   localparam logic [1:0] KPG_P = 2'b01;
   localparam logic [1:0] KPG_G = 2'b11;

   function automatic logic [1:0] kpg_op(input logic [1:0] hi, input logic [1:0] lo);
      return (hi == KPG_P) ? lo : hi;
   endfunction

   logic [LAST:0]         v_q, v_d, rdy, ld;
   logic [WIDTH-1:0]      x_q  [0:LEVELS];
   logic [WIDTH-1:0]      x_d  [0:LEVELS];
   logic [1:0]            c0_q [0:LEVELS];
   logic [1:0]            c0_d [0:LEVELS];
   logic [WIDTH-1:0][1:0] y_q  [0:LEVELS];
   logic [WIDTH-1:0][1:0] y_d  [0:LEVELS];
   logic [WIDTH-1:0]      b_eff, cy, ci;
   logic [WIDTH-1:0]      sum_q, sum_d;
   logic                  cout_q, cout_d, ovf_q, ovf_d;

   // A stage may load when it or any later stage is empty, or the consumer takes this cycle.
   genvar s;
   for (s = 0; s <= LAST; s++) begin : g_rdy
      assign rdy[s] = out_ready | ~(&v_q[LAST:s]);
   end

   always_comb begin
      v_d   = v_q;
      ld    = '0;
      ld[0] = rdy[0] & in_valid;
      if (rdy[0]) v_d[0] = in_valid;
      for (int i = 1; i <= LAST; i++) begin
         ld[i] = rdy[i] & v_q[i-1];
         if (rdy[i]) v_d[i] = v_q[i-1];
      end
   end

   always_comb begin
      b_eff   = sub ? ~b : b;
      x_d[0]  = a ^ b_eff;
      c0_d[0] = (sub | cin) ? KPG_G : KPG_K;
      y_d[0]  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         y_d[0][i] = (a[i] == b_eff[i]) ? {a[i], a[i]} : KPG_P;
      end
      for (int j = 1; j <= LEVELS; j++) begin
         x_d[j]  = x_q[j-1];
         c0_d[j] = c0_q[j-1];
         y_d[j]  = y_q[j-1];
         for (int i = (1 << (j-1)); i < WIDTH; i++) begin
            y_d[j][i] = kpg_op(y_q[j-1][i], y_q[j-1][i - (1 << (j-1))]);
         end
         y_d[j][(1 << (j-1)) - 1] = kpg_op(y_q[j-1][(1 << (j-1)) - 1], c0_q[j-1]);
      end
   end

   // With a power-of-two width the MSB group never meets c0 in the doublings; resolve it here.
   always_comb begin
      cy = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cy[i] = (y_q[LEVELS][i] == KPG_P) ? c0_q[LEVELS][1] : y_q[LEVELS][i][1];
      end
      ci     = {cy[WIDTH-2:0], c0_q[LEVELS][1]};
      sum_d  = x_q[LEVELS] ^ ci;
      cout_d = cy[WIDTH-1];
      ovf_d  = ci[WIDTH-1] ^ cy[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         v_q <= v_d;
         if (ld[LAST]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k <= LEVELS; k++) begin
         if (ld[k]) begin
            x_q[k]  <= x_d[k];
            c0_q[k] <= c0_d[k];
            y_q[k]  <= y_d[k];
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[LAST];
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule
